// File: rtl/pong_pkg.sv
// Shared Pong types and default geometry.
// Used by ball_controller, paddle_overlap, the renderer and the paddle blocks.
//   ball_state_t : ball engine FSM states
//   dir_t        : direction of travel on one axis (POS = right/down, NEG = left/up)
//   PONG_*       : default screen, ball and paddle constants
//   center_coord : top-left coordinate that centres an object on one axis
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } dir_t;

    localparam int unsigned PONG_WIDTH          = 10;
    localparam int unsigned PONG_SCREEN_W       = 640;
    localparam int unsigned PONG_SCREEN_H       = 480;
    localparam int unsigned PONG_BALL_SIZE      = 8;
    localparam int unsigned PONG_PADDLE_W       = 8;
    localparam int unsigned PONG_PADDLE_H       = 48;
    localparam int unsigned PONG_LEFT_PADDLE_X  = 16;
    localparam int unsigned PONG_RIGHT_PADDLE_X = 616;
    localparam int unsigned PONG_STEP           = 2;
    localparam int unsigned PONG_HOLD_TICKS     = 16;

    function automatic int unsigned center_coord(input int unsigned extent,
                                                 input int unsigned size);
        return (extent - size) / 2;
    endfunction

endpackage

// File: rtl/paddle_overlap.sv
// Combinational vertical-overlap test between the ball and one paddle.
//   ball_top_i   : ball top row
//   paddle_top_i : paddle top row
//   overlap_o    : high when the ball and paddle share at least one row
// Sums are taken one bit wider than the coordinates so they cannot wrap.
module paddle_overlap
    import pong_pkg::*;
#(
    parameter int unsigned WIDTH     = PONG_WIDTH,
    parameter int unsigned BALL_SIZE = PONG_BALL_SIZE,
    parameter int unsigned PADDLE_H  = PONG_PADDLE_H
) (
    input  logic [WIDTH-1:0] ball_top_i,
    input  logic [WIDTH-1:0] paddle_top_i,
    output logic             overlap_o
);

    localparam logic [WIDTH:0] BALL_EXT   = (WIDTH+1)'(BALL_SIZE);
    localparam logic [WIDTH:0] PADDLE_EXT = (WIDTH+1)'(PADDLE_H);

    logic [WIDTH:0] ball_bot;
    logic [WIDTH:0] paddle_bot;

    assign ball_bot   = {1'b0, ball_top_i} + BALL_EXT;
    assign paddle_bot = {1'b0, paddle_top_i} + PADDLE_EXT;

    assign overlap_o = (ball_bot > {1'b0, paddle_top_i}) &&
                       ({1'b0, ball_top_i} < paddle_bot);

endmodule

// File: rtl/ball_controller.sv
// Game-rate ball motion engine: holds the ball position and direction,
// advances it by STEP on every tick, bounces off walls and paddles and
// reports misses at the left/right edges.
//   clk, reset                         : clock, async active-high reset
//   tick                               : one-clk game update strobe
//   serve                              : one-clk serve request (IDLE only)
//   left_paddle_top, right_paddle_top  : paddle top rows
//   ball_left, ball_top, ball_visible  : registered ball position / visibility
//   paddle_hit, point_left, point_right: one-cycle event pulses
// Build option: define BALL_AUTO_SERVE_EN to re-serve automatically at the
// end of the post-point hold instead of waiting in IDLE for serve.
//
// state  | meaning
// IDLE   | ball centred and static, waiting for serve
// MOVE   | ball advances on every tick
// SCORED | ball hidden and frozen for HOLD_TICKS ticks after a miss
module ball_controller
    import pong_pkg::*;
#(
    parameter int unsigned WIDTH          = PONG_WIDTH,
    parameter int unsigned SCREEN_W       = PONG_SCREEN_W,
    parameter int unsigned SCREEN_H       = PONG_SCREEN_H,
    parameter int unsigned BALL_SIZE      = PONG_BALL_SIZE,
    parameter int unsigned PADDLE_W       = PONG_PADDLE_W,
    parameter int unsigned PADDLE_H       = PONG_PADDLE_H,
    parameter int unsigned LEFT_PADDLE_X  = PONG_LEFT_PADDLE_X,
    parameter int unsigned RIGHT_PADDLE_X = PONG_RIGHT_PADDLE_X,
    parameter int unsigned STEP           = PONG_STEP,
    parameter int unsigned HOLD_TICKS     = PONG_HOLD_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             serve,
    input  logic [WIDTH-1:0] left_paddle_top,
    input  logic [WIDTH-1:0] right_paddle_top,
    output logic [WIDTH-1:0] ball_left,
    output logic [WIDTH-1:0] ball_top,
    output logic             ball_visible,
    output logic             paddle_hit,
    output logic             point_left,
    output logic             point_right
);

    localparam int unsigned       HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

    localparam logic [WIDTH:0] STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] FACE_R   = (WIDTH+1)'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [WIDTH:0] FACE_L   = (WIDTH+1)'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [WIDTH:0] MAX_LEFT = (WIDTH+1)'(SCREEN_W - BALL_SIZE);
    localparam logic [WIDTH:0] MAX_TOP  = (WIDTH+1)'(SCREEN_H - BALL_SIZE);

    localparam logic [WIDTH-1:0] CENTER_X = WIDTH'(center_coord(SCREEN_W, BALL_SIZE));
    localparam logic [WIDTH-1:0] CENTER_Y = WIDTH'(center_coord(SCREEN_H, BALL_SIZE));

    ball_state_t       state_q, state_d;
    logic [WIDTH-1:0]  left_q, left_d;
    logic [WIDTH-1:0]  top_q, top_d;
    dir_t              dx_q, dx_d;
    dir_t              dy_q, dy_d;
    logic              visible_q, visible_d;
    logic              hit_q, hit_d;
    logic              pt_left_q, pt_left_d;
    logic              pt_right_q, pt_right_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic             overlap_l, overlap_r;
    logic [WIDTH:0]   l_ext, t_ext;
    logic             miss_r, miss_l;
    logic             cross_r, cross_l;
    logic [WIDTH-1:0] x_next, y_next;
    dir_t             x_dir, y_dir;

    paddle_overlap #(
        .WIDTH    (WIDTH),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_H (PADDLE_H)
    ) u_overlap_left (
        .ball_top_i  (top_q),
        .paddle_top_i(left_paddle_top),
        .overlap_o   (overlap_l)
    );

    paddle_overlap #(
        .WIDTH    (WIDTH),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_H (PADDLE_H)
    ) u_overlap_right (
        .ball_top_i  (top_q),
        .paddle_top_i(right_paddle_top),
        .overlap_o   (overlap_r)
    );

    // Candidate next position from the pre-update position; both axes are
    // resolved independently and only committed on a MOVE tick.
    always_comb begin
        l_ext = {1'b0, left_q};
        t_ext = {1'b0, top_q};

        miss_r  = (dx_q == POS) && ((l_ext + STEP_X) > MAX_LEFT);
        miss_l  = (dx_q == NEG) && (l_ext < STEP_X);
        // Face crossed during this step; FACE_L + STEP >= left avoids an
        // underflowing subtraction on the mirrored test.
        cross_r = (dx_q == POS) && (l_ext < FACE_R) && (FACE_R <= (l_ext + STEP_X));
        cross_l = (dx_q == NEG) && (l_ext > FACE_L) && ((FACE_L + STEP_X) >= l_ext);

        x_dir = dx_q;
        if (cross_r && overlap_r) begin
            x_next = WIDTH'(FACE_R);
            x_dir  = NEG;
        end else if (cross_l && overlap_l) begin
            x_next = WIDTH'(FACE_L);
            x_dir  = POS;
        end else if (dx_q == POS) begin
            x_next = WIDTH'(l_ext + STEP_X);
        end else begin
            x_next = WIDTH'(l_ext - STEP_X);
        end

        y_dir = dy_q;
        if ((dy_q == NEG) && (t_ext < STEP_X)) begin
            y_next = '0;
            y_dir  = POS;
        end else if ((dy_q == POS) && ((t_ext + STEP_X) > MAX_TOP)) begin
            y_next = WIDTH'(MAX_TOP);
            y_dir  = NEG;
        end else if (dy_q == POS) begin
            y_next = WIDTH'(t_ext + STEP_X);
        end else begin
            y_next = WIDTH'(t_ext - STEP_X);
        end
    end

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        top_d      = top_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        visible_d  = visible_q;
        hold_d     = hold_q;
        hit_d      = 1'b0;
        pt_left_d  = 1'b0;
        pt_right_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (serve) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (tick) begin
                    if (miss_r || miss_l) begin
                        // Position freezes; dx already points at the side
                        // that conceded, which is where the next serve goes.
                        state_d    = SCORED;
                        visible_d  = 1'b0;
                        hold_d     = HOLD_LOAD;
                        pt_left_d  = miss_r;
                        pt_right_d = miss_l;
                    end else begin
                        left_d = x_next;
                        top_d  = y_next;
                        dx_d   = x_dir;
                        dy_d   = y_dir;
                        hit_d  = (cross_r && overlap_r) || (cross_l && overlap_l);
                    end
                end
            end
            SCORED: begin
                if (tick) begin
                    if (hold_q == '0) begin
                        left_d    = CENTER_X;
                        top_d     = CENTER_Y;
                        dy_d      = POS;
                        visible_d = 1'b1;
`ifdef BALL_AUTO_SERVE_EN
                        state_d   = MOVE;
`else
                        state_d   = IDLE;
`endif
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            left_q     <= CENTER_X;
            top_q      <= CENTER_Y;
            dx_q       <= POS;
            dy_q       <= POS;
            visible_q  <= 1'b1;
            hold_q     <= '0;
            hit_q      <= 1'b0;
            pt_left_q  <= 1'b0;
            pt_right_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            top_q      <= top_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            visible_q  <= visible_d;
            hold_q     <= hold_d;
            hit_q      <= hit_d;
            pt_left_q  <= pt_left_d;
            pt_right_q <= pt_right_d;
        end
    end

    assign ball_left    = left_q;
    assign ball_top     = top_q;
    assign ball_visible = visible_q;
    assign paddle_hit   = hit_q;
    assign point_left   = pt_left_q;
    assign point_right  = pt_right_q;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: walks the ball through wall bounces,
// both paddle bounces, a pass-through, right and left misses, the hold
// period, serve handling and asynchronous reset.
module tb_ball_controller;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       serve;
    logic [9:0] left_paddle_top;
    logic [9:0] right_paddle_top;
    logic [9:0] ball_left;
    logic [9:0] ball_top;
    logic       ball_visible;
    logic       paddle_hit;
    logic       point_left;
    logic       point_right;

    int n_checks = 0;
    int n_errors = 0;
    int n_hit    = 0;
    int n_pl     = 0;
    int n_pr     = 0;
    int n_multi  = 0;

    ball_controller dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .serve           (serve),
        .left_paddle_top (left_paddle_top),
        .right_paddle_top(right_paddle_top),
        .ball_left       (ball_left),
        .ball_top        (ball_top),
        .ball_visible    (ball_visible),
        .paddle_hit      (paddle_hit),
        .point_left      (point_left),
        .point_right     (point_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally sampled mid-cycle; each one-cycle pulse is seen once.
    always @(negedge clk) begin
        if (!reset) begin
            n_hit = n_hit + int'(paddle_hit);
            n_pl  = n_pl + int'(point_left);
            n_pr  = n_pr + int'(point_right);
            if ((int'(paddle_hit) + int'(point_left) + int'(point_right)) > 1)
                n_multi = n_multi + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int l, input int t, input int v);
        check({tag, ".left"}, 32'(ball_left), 32'(l));
        check({tag, ".top"},  32'(ball_top),  32'(t));
        check({tag, ".vis"},  32'(ball_visible), 32'(v));
    endtask

    task automatic check_pulses(input string tag, input int h, input int pl, input int pr);
        check({tag, ".hit"}, 32'(paddle_hit),  32'(h));
        check({tag, ".pl"},  32'(point_left),  32'(pl));
        check({tag, ".pr"},  32'(point_right), 32'(pr));
    endtask

    // Returns on the negedge right after the last tick edge, so any pulse
    // produced by that tick is visible to the caller.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic do_serve();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        tick             = 1'b0;
        serve            = 1'b0;
        left_paddle_top  = 10'd150;
        right_paddle_top = 10'd420;
        #1 reset = 1'b1;
        #2;
        check_ball("rst", 316, 236, 1);
        check_pulses("rst", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // IDLE ignores ticks
        do_ticks(5);
        check_ball("idle5", 316, 236, 1);

        // tick and serve together: serve taken, no motion
        @(negedge clk);
        tick  = 1'b1;
        serve = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        serve = 1'b0;
        check_ball("srv_tick", 316, 236, 1);

        do_ticks(1);
        check_ball("t1", 318, 238, 1);
        do_ticks(117);
        check_ball("t118", 552, 472, 1);
        do_ticks(1);
        check_ball("t119_clamp", 554, 472, 1);
        check_pulses("t119", 0, 0, 0);
        do_ticks(1);
        check_ball("t120_up", 556, 470, 1);
        do_ticks(25);
        check_ball("t145", 606, 420, 1);

        // right paddle bounce
        do_ticks(1);
        check_ball("rhit", 608, 418, 1);
        check_pulses("rhit", 1, 0, 0);
        @(negedge clk);
        check("rhit_one_cycle", 32'(paddle_hit), 32'd0);
        do_ticks(1);
        check_ball("rhit_next", 606, 416, 1);

        // top wall, then left paddle bounce
        do_ticks(208);
        check_ball("top_reach", 190, 0, 1);
        do_ticks(1);
        check_ball("top_clamp", 188, 0, 1);
        do_ticks(1);
        check_ball("top_down", 186, 2, 1);
        do_ticks(81);
        check_ball("lhit", 24, 164, 1);
        check_pulses("lhit", 1, 0, 0);
        #1;
        check("hits_so_far", 32'(n_hit), 32'd2);

        // pass through the right paddle, then miss on the right
        right_paddle_top = 10'd0;
        do_ticks(292);
        check_ball("rpass", 608, 198, 1);
        do_ticks(12);
        check_ball("redge", 632, 174, 1);
        check_pulses("redge", 0, 0, 0);
        do_ticks(1);
        check_ball("rmiss", 632, 174, 0);
        check_pulses("rmiss", 0, 1, 0);
        @(negedge clk);
        check("rmiss_one_cycle", 32'(point_left), 32'd0);

        // hold period; serve outside IDLE is ignored
        do_ticks(15);
        check_ball("hold15", 632, 174, 0);
        do_serve();
        check_ball("hold_serve", 632, 174, 0);
        do_ticks(1);
        check_ball("hold16", 316, 236, 1);
`ifdef BALL_AUTO_SERVE_EN
        do_ticks(1);
        check_ball("auto_move", 318, 238, 1);
`else
        do_ticks(3);
        check_ball("back_idle", 316, 236, 1);
        do_serve();
        do_ticks(1);
        check_ball("reserve_r", 318, 238, 1);
`endif
        do_ticks(2);
        check_ball("pre_rst", 322, 242, 1);

        // async reset between edges, mid-MOVE
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_ball("mid_rst", 316, 236, 1);
        check_pulses("mid_rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        do_ticks(2);
        check_ball("rst_idle", 316, 236, 1);

        // second rally: right bounce, left pass-through, left miss
        right_paddle_top = 10'd420;
        left_paddle_top  = 10'd0;
        do_serve();
        do_ticks(146);
        check_ball("r2_rhit", 608, 418, 1);
        check_pulses("r2_rhit", 1, 0, 0);
        do_ticks(292);
        check_ball("r2_lpass", 24, 164, 1);
        do_ticks(12);
        check_ball("r2_ledge", 0, 188, 1);
        do_ticks(1);
        check_ball("r2_lmiss", 0, 188, 0);
        check_pulses("r2_lmiss", 0, 0, 1);
        do_ticks(16);
        check_ball("r2_recentre", 316, 236, 1);
`ifndef BALL_AUTO_SERVE_EN
        do_serve();
`endif
        do_ticks(1);
        check_ball("r2_serve_left", 314, 238, 1);

        #1;
        check("hit_count", 32'(n_hit), 32'd3);
        check("pl_count", 32'(n_pl), 32'd1);
        check("pr_count", 32'(n_pr), 32'd1);
        check("pulse_overlap", 32'(n_multi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
